invader_fleet: RTL

//   Owns the invader formation state: 55-bit alive mask, fleet origin (invaders_x/_y), march direction and step timing.

---
 rtl/invader_fleet.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/invader_fleet.sv
`timescale 1ns/1ps
// invader_fleet: invader formation state (alive mask, fleet origin, march direction and step timing).
// Removes hit invaders, steps the fleet on frame pulses and reports wave clear / fleet landed.
module invader_fleet #(
    parameter int unsigned INVADERS_H = 11,
    parameter int unsigned INVADERS_V = 5,
    parameter int unsigned OFFSET_H   = 40,
    parameter int unsigned OFFSET_V   = 32,
    parameter int unsigned SPR_W      = 32,
    parameter int unsigned SPR_H      = 24,
    parameter int unsigned X_START    = 96,
    parameter int unsigned Y_START    = 64,
    parameter int unsigned X_MIN      = 16,
    parameter int unsigned X_MAX      = 624,
    parameter int unsigned STEP_X     = 4,
    parameter int unsigned STEP_Y     = 16,
    parameter int unsigned Y_LIMIT    = 416,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        start,
    input  logic [5:0]  invader_collision,
    output logic [54:0] invaders,
    output logic [9:0]  invaders_x,
    output logic [9:0]  invaders_y,
    output logic        kill_pulse,
    output logic [2:0]  kill_row,
    output logic        wave_clear,
    output logic        fleet_landed
);
    localparam int unsigned NUM  = INVADERS_H * INVADERS_V;
    localparam int unsigned PW   = 11;
    localparam int unsigned OW   = 10;
    localparam int unsigned IW   = 6;
    localparam int unsigned PADW = 1 << IW;
    localparam int unsigned CW   = 4;
    localparam int unsigned RW   = 3;
    localparam int unsigned CNTW = 6;

    typedef enum logic [1:0] {S_IDLE, S_MARCH, S_CLEAR, S_LANDED} state_t;

    state_t          state, state_nxt;
    logic [NUM-1:0]  mask, mask_nxt;
    logic [OW-1:0]   pos_x, pos_x_nxt, pos_y, pos_y_nxt;
    logic            dir_right, dir_right_nxt;
    logic [CNTW-1:0] frame_cnt, frame_cnt_nxt;
    logic            kill_pulse_nxt;
    logic [RW-1:0]   kill_row_nxt;
    logic            wave_clear_nxt, fleet_landed_nxt;

    logic [INVADERS_H-1:0] col_any;
    logic [INVADERS_V-1:0] row_any;
    logic [CW-1:0]         lcol, rcol;
    logic [RW-1:0]         brow;
    logic [CNTW-1:0]       alive_cnt, period_m1;
    logic                  step_due;

    logic [IW-1:0]  hit_idx;
    logic [NUM-1:0] hit_bit;
    logic           hit_valid;
    logic [RW-1:0]  hit_row;

    logic [PW-1:0] x_ext, y_ext, left_edge, right_edge, x_step, y_step;
    logic          dir_step, landed_now;

    // Live extents and alive count of the registered mask
    always_comb begin
        col_any   = '0;
        row_any   = '0;
        lcol      = '0;
        rcol      = '0;
        brow      = '0;
        alive_cnt = '0;
        for (int r = 0; r < INVADERS_V; r++) begin
            for (int c = 0; c < INVADERS_H; c++) begin
                col_any[c] = col_any[c] | mask[r*INVADERS_H + c];
                row_any[r] = row_any[r] | mask[r*INVADERS_H + c];
            end
        end
        for (int c = INVADERS_H - 1; c >= 0; c--) begin
            if (col_any[c]) lcol = CW'(c);
        end
        for (int c = 0; c < INVADERS_H; c++) begin
            if (col_any[c]) rcol = CW'(c);
        end
        for (int r = 0; r < INVADERS_V; r++) begin
            if (row_any[r]) brow = RW'(r);
        end
        for (int k = 0; k < NUM; k++) begin
            alive_cnt = alive_cnt + CNTW'(mask[k]);
        end
    end

    assign period_m1 = CNTW'(MIN_PERIOD - 1) + (alive_cnt >> 1);
    assign step_due  = frame_cnt >= period_m1;

    // Out-of-range indices shift past the mask and never match a live bit
    assign hit_idx   = invader_collision - IW'(1);
    assign hit_bit   = NUM'(PADW'(1) << hit_idx);
    assign hit_valid = (invader_collision != '0) && ((hit_bit & mask) != '0);
    assign hit_row   = RW'(hit_idx / IW'(INVADERS_H));

    assign x_ext      = PW'(pos_x);
    assign y_ext      = PW'(pos_y);
    assign left_edge  = x_ext + PW'(lcol) * PW'(OFFSET_H);
    assign right_edge = x_ext + PW'(rcol) * PW'(OFFSET_H) + PW'(SPR_W);

    // Candidate position after one march step
    always_comb begin
        x_step   = x_ext;
        y_step   = y_ext;
        dir_step = dir_right;
        if (dir_right) begin
            if (right_edge + PW'(STEP_X) > PW'(X_MAX)) begin
                y_step   = y_ext + PW'(STEP_Y);
                dir_step = 1'b0;
            end else begin
                x_step = x_ext + PW'(STEP_X);
            end
        end else begin
            // Also turn before the origin itself would drop below zero
            if ((left_edge < PW'(X_MIN + STEP_X)) || (x_ext < PW'(STEP_X))) begin
                y_step   = y_ext + PW'(STEP_Y);
                dir_step = 1'b1;
            end else begin
                x_step = x_ext - PW'(STEP_X);
            end
        end
        landed_now = (y_step + PW'(brow) * PW'(OFFSET_V) + PW'(SPR_H)) >= PW'(Y_LIMIT);
    end

    // Next-state and registered outputs
    always_comb begin
        state_nxt        = state;
        mask_nxt         = mask;
        pos_x_nxt        = pos_x;
        pos_y_nxt        = pos_y;
        dir_right_nxt    = dir_right;
        frame_cnt_nxt    = frame_cnt;
        kill_pulse_nxt   = 1'b0;
        kill_row_nxt     = kill_row;
        wave_clear_nxt   = wave_clear;
        fleet_landed_nxt = fleet_landed;
        if (start) begin
            state_nxt        = S_MARCH;
            mask_nxt         = '1;
            pos_x_nxt        = OW'(X_START);
            pos_y_nxt        = OW'(Y_START);
            dir_right_nxt    = 1'b1;
            frame_cnt_nxt    = '0;
            wave_clear_nxt   = 1'b0;
            fleet_landed_nxt = 1'b0;
        end else if (state == S_MARCH) begin
            if (mask == '0) begin
                state_nxt      = S_CLEAR;
                wave_clear_nxt = 1'b1;
            end else begin
                if (hit_valid) begin
                    mask_nxt       = mask & ~hit_bit;
                    kill_pulse_nxt = 1'b1;
                    kill_row_nxt   = hit_row;
                end
                if (frame) begin
                    if (step_due) begin
                        frame_cnt_nxt = '0;
                        pos_x_nxt     = OW'(x_step);
                        pos_y_nxt     = OW'(y_step);
                        dir_right_nxt = dir_step;
                        if (landed_now) begin
                            state_nxt        = S_LANDED;
                            fleet_landed_nxt = 1'b1;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt + CNTW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mask         <= '1;
            pos_x        <= OW'(X_START);
            pos_y        <= OW'(Y_START);
            dir_right    <= 1'b1;
            frame_cnt    <= '0;
            kill_pulse   <= 1'b0;
            kill_row     <= '0;
            wave_clear   <= 1'b0;
            fleet_landed <= 1'b0;
        end else begin
            state        <= state_nxt;
            mask         <= mask_nxt;
            pos_x        <= pos_x_nxt;
            pos_y        <= pos_y_nxt;
            dir_right    <= dir_right_nxt;
            frame_cnt    <= frame_cnt_nxt;
            kill_pulse   <= kill_pulse_nxt;
            kill_row     <= kill_row_nxt;
            wave_clear   <= wave_clear_nxt;
            fleet_landed <= fleet_landed_nxt;
        end
    end

    assign invaders   = mask;
    assign invaders_x = pos_x;
    assign invaders_y = pos_y;

endmodule
